la_capture_sequencer: RTL and testbench
=======================================

Name: la_capture_sequencer

Overview:
- Run-level controller for the logic-analyser capture/upload path.
- Synchronises the operator `sample_run` level and sequences one acquisition: DDR ready → capture start pulse → capture complete → Ethernet upload complete.
- Latches the capture configuration so the capture core and UDP sender see stable values for the whole run.
- Enforces per-phase timeouts and reports status and an error code. Sits between the control/PicoRV32 registers and the capture-core/UDP-sender pair; all of it runs in the `clk` domain.

Parameters:
- TIMEOUT_CYCLES, 32'd200_000_000: per-phase watchdog limit in clk cycles; 0 disables all timeouts.
- CNT_WIDTH, 16: width of `run_count`.
- SYNC_STAGES, 2: flip-flop stages on `sample_run`; minimum 2.

Ports:
- clk  input  1  system clock; everything is sampled on its rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- sample_run  input  1  asynchronous run request level; a rising edge starts a run.
- abort  input  1  synchronous single-cycle abort request.
- sample_clk_cfg  input  4  requested sample-rate code.
- sample_num  input  32  requested sample count.
- triger_type  input  2  requested trigger type.
- trigger_channel  input  3  requested trigger channel.
- ddr_init_done  input  1  DDR calibration complete (level, clk domain).
- dout_done  input  1  capture core finished writing DDR (pulse or level).
- ethernet_read_done  input  1  UDP sender drained all data (pulse or level, clk domain).
- start_posedge  output  1  one-cycle capture start pulse to the capture core and UDP sender.
- cfg_sample_clk  output  4  latched sample-rate code.
- cfg_sample_num  output  32  latched sample count.
- cfg_triger_type  output  2  latched trigger type.
- cfg_trig_chan  output  3  latched trigger channel.
- busy  output  1  high in every state except IDLE and ERROR.
- run_done  output  1  one-cycle pulse when a run completes.
- state  output  3  current state encoding.
- err_code  output  3  sticky error cause.
- run_count  output  CNT_WIDTH  number of completed runs; wraps.
- led_busy  output  1  copy of `busy`.
- led_err  output  1  high while in ERROR.

Behaviour:
- Reset values: all outputs 0; state = IDLE; all cfg_* = 0; timeout counter = 0.
- Run request: `sample_run` passes through SYNC_STAGES flops; `rise` = synchronised value & ~its previous value. `rise` is ignored in every state except IDLE and ERROR.
- States and encodings: IDLE=0, WAIT_INIT=1, START=2, CAPTURE=3, UPLOAD=4, DONE=5, ERROR=6.
- IDLE, on `rise`:
  - Latch all four config inputs into cfg_*; clear `err_code`.
  - If `sample_num` == 0: go to ERROR with err=1.
  - Else if `!ddr_init_done`: go to WAIT_INIT.
  - Else: go to START.
- WAIT_INIT: `ddr_init_done` → START. Timeout → ERROR, err=2.
- START: lasts exactly one cycle, then → CAPTURE.
- CAPTURE: `dout_done` → UPLOAD. Timeout → ERROR, err=3. `ethernet_read_done` is ignored here.
- UPLOAD: `ethernet_read_done` → DONE. Timeout → ERROR, err=4.
- DONE: lasts one cycle. `run_done` = 1 and `run_count` +1 (wraps at 2^CNT_WIDTH), then → IDLE.
- ERROR:
  - `err_code` holds; `led_err` = 1.
  - `rise` starts a new run exactly as from IDLE, including config latch and err clear.
  - `abort` → IDLE with err cleared.
- `start_posedge` is registered; it is high exactly during the single START cycle. Latency: with `ddr_init_done` high, `start_posedge` rises on the (SYNC_STAGES+1)th clk edge after `sample_run` is first sampled high; that is 3 edges at the default.
- `abort` in WAIT_INIT, START, CAPTURE or UPLOAD → ERROR, err=5. `abort` in IDLE or DONE is ignored.
- Priority on a same-cycle event: abort > phase-complete input > timeout.
- Timeout counter:
  - Clears on every state transition and counts only in WAIT_INIT, CAPTURE and UPLOAD.
  - A timeout fires when the counter == TIMEOUT_CYCLES−1.
  - It never fires when TIMEOUT_CYCLES == 0.
- cfg_* values change only on the latch event; changes to the input config during a run have no effect.
- Asynchronous reset mid-run returns to IDLE immediately and produces no `run_done`.

Decomposition:
- Package `la_seq_pkg`:
  - state encodings ST_IDLE..ST_ERROR;
  - error codes ERR_NONE=0, ERR_ZERO_NUM=1, ERR_DDR_TO=2, ERR_CAP_TO=3, ERR_UP_TO=4, ERR_ABORT=5.
- Sub-module `la_sync_edge`: parameter STAGES; ports clk, rst_n, async_in, sync_out, rise. Implements the multi-flop synchroniser plus rising-edge detect.
- The FSM, config latch, watchdog and counters stay in the top module.

Test Plan:
- Nominal run (ddr_init_done=1, sample_num=32'h3FDD): raise sample_run; pulse dout_done after 50 cycles, then ethernet_read_done after 20 more. Expect start_posedge for 1 cycle at the 3rd edge, states 0→2→3→4→5→0, run_done=1 once, run_count=1, err_code=0.
- DDR not ready (ddr_init_done=0 at rise, high 100 cycles later) → stays in WAIT_INIT for 100 cycles; start_posedge fires exactly 1 cycle after ddr_init_done rises.
- Zero count (sample_num=0, raise sample_run) → ERROR, err_code=1, led_err=1, start_posedge never asserts.
- Watchdog (TIMEOUT_CYCLES=1000; dout_done held low) → ERROR entered exactly 1000 cycles after entering CAPTURE, err_code=3. A new sample_run rise then starts a clean run with err_code=0.
- Priority (abort and dout_done in the same CAPTURE cycle) → ERROR with err_code=5. Then abort in ERROR → IDLE with err_code=0.
- Config stability: change sample_num from 100 to 200 during CAPTURE → cfg_sample_num stays 100. Rising edges of sample_run during the run are ignored, and run_count increments only once.

Source files
------------

// File: rtl/la_seq_pkg.sv
// Shared types for the logic-analyser capture sequencer.
// State and error encodings, latched config bundle, small helpers.
package la_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_INIT = 3'd1,
    ST_START     = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_UPLOAD    = 3'd4,
    ST_DONE      = 3'd5,
    ST_ERROR     = 3'd6
  } st_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_ZERO_NUM = 3'd1,
    ERR_DDR_TO   = 3'd2,
    ERR_CAP_TO   = 3'd3,
    ERR_UP_TO    = 3'd4,
    ERR_ABORT    = 3'd5
  } err_e;

  typedef struct packed {
    logic [3:0]  sample_clk;
    logic [31:0] sample_num;
    logic [1:0]  triger_type;
    logic [2:0]  trig_chan;
  } cfg_t;

  // Phases that are guarded by the watchdog.
  function automatic logic timed_phase(st_e s);
    return (s == ST_WAIT_INIT) ||
           (s == ST_CAPTURE) ||
           (s == ST_UPLOAD);
  endfunction

  // Where a freshly requested run goes.
  function automatic st_e launch_state(
    logic [31:0] num,
    logic        ddr_ok
  );
    if (num == 32'd0)
      return ST_ERROR;
    else if (!ddr_ok)
      return ST_WAIT_INIT;
    else
      return ST_START;
  endfunction

  function automatic err_e launch_err(
    logic [31:0] num
  );
    return (num == 32'd0) ? ERR_ZERO_NUM
                          : ERR_NONE;
  endfunction

endpackage

// File: rtl/la_sync_edge.sv
// Multi-flop synchroniser with rising-edge detect.
// Ports: clk, rst_n, async_in -> sync_out (level), rise (1-cycle).
module la_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic [STAGES-1:0] sh_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      prev_q <= 1'b0;
    end else begin
      sh_q   <= {sh_q[STAGES-2:0], async_in};
      prev_q <= sh_q[STAGES-1];
    end
  end

  assign sync_out = sh_q[STAGES-1];
  assign rise     = sh_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/la_capture_sequencer.sv
// Run-level controller: sync run request, latch config, sequence
// DDR-ready/start/capture/upload with per-phase watchdog and status.
// In : clk, rst_n, sample_run, abort, cfg requests, ddr/dout/eth done.
// Out: start_posedge, cfg_*, busy, run_done, state, err_code,
//      run_count, led_busy, led_err.
module la_capture_sequencer
  import la_seq_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd200_000_000,
  parameter int          CNT_WIDTH      = 16,
  parameter int          SYNC_STAGES    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_run,
  input  logic                 abort,
  input  logic [3:0]           sample_clk_cfg,
  input  logic [31:0]          sample_num,
  input  logic [1:0]           triger_type,
  input  logic [2:0]           trigger_channel,
  input  logic                 ddr_init_done,
  input  logic                 dout_done,
  input  logic                 ethernet_read_done,
  output logic                 start_posedge,
  output logic [3:0]           cfg_sample_clk,
  output logic [31:0]          cfg_sample_num,
  output logic [1:0]           cfg_triger_type,
  output logic [2:0]           cfg_trig_chan,
  output logic                 busy,
  output logic                 run_done,
  output logic [2:0]           state,
  output logic [2:0]           err_code,
  output logic [CNT_WIDTH-1:0] run_count,
  output logic                 led_busy,
  output logic                 led_err
);

  localparam logic        TMO_EN   = (TIMEOUT_CYCLES != 32'd0);
  localparam logic [31:0] TMO_LAST = TIMEOUT_CYCLES - 32'd1;

  st_e                  st_q;
  st_e                  st_d;
  err_e                 err_q;
  err_e                 err_d;
  cfg_t                 cfg_q;
  logic                 latch;
  logic                 start_q;
  logic [31:0]          tmo_q;
  logic                 tmo_hit;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 rise;

  la_sync_edge #(
    .STAGES   (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (sample_run),
    .sync_out (),
    .rise     (rise)
  );

  // Only fires while the counter is actually running in a guarded phase.
  assign tmo_hit = TMO_EN &&
                   timed_phase(st_q) &&
                   (tmo_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= ST_IDLE;
      err_q   <= ERR_NONE;
      cfg_q   <= '0;
      start_q <= 1'b0;
      tmo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      st_q    <= st_d;
      err_q   <= err_d;
      start_q <= (st_d == ST_START);
      if (latch) begin
        cfg_q <= '{
          sample_clk:  sample_clk_cfg,
          sample_num:  sample_num,
          triger_type: triger_type,
          trig_chan:   trigger_channel
        };
      end
      if ((st_d != st_q) || !timed_phase(st_q))
        tmo_q <= '0;
      else
        tmo_q <= tmo_q + 32'd1;
      if (st_d == ST_DONE)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  // Next state: abort beats phase completion, which beats timeout.
  always_comb begin
    st_d  = st_q;
    err_d = err_q;
    latch = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (rise) begin
          latch = 1'b1;
          st_d  = launch_state(sample_num, ddr_init_done);
          err_d = launch_err(sample_num);
        end
      end
      ST_WAIT_INIT: begin
        if (abort) begin
          st_d  = ST_ERROR;
          err_d = ERR_ABORT;
        end else if (ddr_init_done) begin
          st_d  = ST_START;
        end else if (tmo_hit) begin
          st_d  = ST_ERROR;
          err_d = ERR_DDR_TO;
        end
      end
      ST_START: begin
        if (abort) begin
          st_d  = ST_ERROR;
          err_d = ERR_ABORT;
        end else begin
          st_d  = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (abort) begin
          st_d  = ST_ERROR;
          err_d = ERR_ABORT;
        end else if (dout_done) begin
          st_d  = ST_UPLOAD;
        end else if (tmo_hit) begin
          st_d  = ST_ERROR;
          err_d = ERR_CAP_TO;
        end
      end
      ST_UPLOAD: begin
        if (abort) begin
          st_d  = ST_ERROR;
          err_d = ERR_ABORT;
        end else if (ethernet_read_done) begin
          st_d  = ST_DONE;
        end else if (tmo_hit) begin
          st_d  = ST_ERROR;
          err_d = ERR_UP_TO;
        end
      end
      ST_DONE: begin
        st_d = ST_IDLE;
      end
      ST_ERROR: begin
        if (abort) begin
          st_d  = ST_IDLE;
          err_d = ERR_NONE;
        end else if (rise) begin
          latch = 1'b1;
          st_d  = launch_state(sample_num, ddr_init_done);
          err_d = launch_err(sample_num);
        end
      end
      default: begin
        st_d  = ST_IDLE;
        err_d = ERR_NONE;
      end
    endcase
  end

  always_comb begin
    busy            = (st_q != ST_IDLE) && (st_q != ST_ERROR);
    led_busy        = busy;
    led_err         = (st_q == ST_ERROR);
    run_done        = (st_q == ST_DONE);
    state           = st_q;
    err_code        = err_q;
    start_posedge   = start_q;
    run_count       = cnt_q;
    cfg_sample_clk  = cfg_q.sample_clk;
    cfg_sample_num  = cfg_q.sample_num;
    cfg_triger_type = cfg_q.triger_type;
    cfg_trig_chan   = cfg_q.trig_chan;
  end

endmodule

// File: tb/tb_la_capture_sequencer.sv
// Bench for la_capture_sequencer: run table plus scoreboard,
// hand sequences for abort handling and mid-run reset.
module tb_la_capture_sequencer;

  localparam int TMO = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_run;
  logic        abort;
  logic [3:0]  sample_clk_cfg;
  logic [31:0] sample_num;
  logic [1:0]  triger_type;
  logic [2:0]  trigger_channel;
  logic        ddr_init_done;
  logic        dout_done;
  logic        ethernet_read_done;
  logic        start_posedge;
  logic [3:0]  cfg_sample_clk;
  logic [31:0] cfg_sample_num;
  logic [1:0]  cfg_triger_type;
  logic [2:0]  cfg_trig_chan;
  logic        busy;
  logic        run_done;
  logic [2:0]  state;
  logic [2:0]  err_code;
  logic [15:0] run_count;
  logic        led_busy;
  logic        led_err;

  la_capture_sequencer #(
    .TIMEOUT_CYCLES (32'd1000),
    .CNT_WIDTH      (16),
    .SYNC_STAGES    (2)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .sample_run         (sample_run),
    .abort              (abort),
    .sample_clk_cfg     (sample_clk_cfg),
    .sample_num         (sample_num),
    .triger_type        (triger_type),
    .trigger_channel    (trigger_channel),
    .ddr_init_done      (ddr_init_done),
    .dout_done          (dout_done),
    .ethernet_read_done (ethernet_read_done),
    .start_posedge      (start_posedge),
    .cfg_sample_clk     (cfg_sample_clk),
    .cfg_sample_num     (cfg_sample_num),
    .cfg_triger_type    (cfg_triger_type),
    .cfg_trig_chan      (cfg_trig_chan),
    .busy               (busy),
    .run_done           (run_done),
    .state              (state),
    .err_code           (err_code),
    .run_count          (run_count),
    .led_busy           (led_busy),
    .led_err            (led_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] num;
    logic [3:0]  sclk;
    logic [1:0]  trig;
    logic [2:0]  chan;
    int          d;
    int          c;
    int          u;
    bit          ab;
    bit          chg;
  } vec_t;

  typedef struct {
    int          err;
    bit          done;
    int          start_step;
    int          end_step;
    logic [31:0] cfg_num;
    logic [3:0]  cfg_clk;
    logic [1:0]  cfg_trig;
    logic [2:0]  cfg_chan;
    int          rc;
    logic [23:0] path;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   m_rc  = 0;
  int   m_st  = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] push3(logic [23:0] p, int s);
    return {p[20:0], 3'(s)};
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    exp_t g;
    int n, s, sc, dc;
    bit term;
    logic [23:0] mp;
    logic [2:0]  last;
    string tag;
    tag = $sformatf("v%0d", idx);
    // expected outcome from the spec timeline
    e.done = (v.num != 0) && !v.ab && (v.c > 0) && (v.u > 0);
    e.start_step = (v.num == 0) ? -1 : 3 + v.d;
    if (v.num == 0)     begin e.err = 1; e.end_step = 3; end
    else if (v.ab)      begin e.err = 5; e.end_step = e.start_step + v.c + 1; end
    else if (v.c == 0)  begin e.err = 3; e.end_step = e.start_step + 1 + TMO; end
    else if (v.u == 0)  begin e.err = 4; e.end_step = e.start_step + v.c + 1 + TMO; end
    else                begin e.err = 0; e.end_step = e.start_step + v.c + v.u + 1; end
    e.cfg_num  = v.num;
    e.cfg_clk  = v.sclk;
    e.cfg_trig = v.trig;
    e.cfg_chan = v.chan;
    e.rc = (m_rc + (e.done ? 1 : 0)) & 16'hFFFF;
    e.path = 24'(m_st);
    if (v.num == 0) e.path = push3(e.path, 6);
    else begin
      if (v.d > 0) e.path = push3(e.path, 1);
      e.path = push3(e.path, 2);
      e.path = push3(e.path, 3);
      if (v.ab || v.c == 0) e.path = push3(e.path, 6);
      else begin
        e.path = push3(e.path, 4);
        e.path = push3(e.path, (v.u == 0) ? 6 : 5);
      end
    end
    // drive
    sample_clk_cfg  = v.sclk;
    sample_num      = v.num;
    triger_type     = v.trig;
    trigger_channel = v.chan;
    ddr_init_done   = (v.d == 0);
    sample_run      = 1'b1;
    sb.push_back(e);
    n = 0; s = -1; sc = 0; dc = 0; term = 1'b0;
    mp = 24'(state);
    last = state;
    while (!term && n < 3000) begin
      step();
      n++;
      if (state != last) begin
        mp = push3(mp, int'(state));
        last = state;
      end
      if (start_posedge) begin
        sc++;
        if (s < 0) s = n;
      end
      if (run_done) dc++;
      if (n == 3 && v.num != 0)
        chk({tag, "_err_clr"}, 32'(err_code), 32'd0);
      term = run_done || (led_err && n >= 3);
      if (v.d > 0 && n == 2 + v.d) ddr_init_done = 1'b1;
      if (s >= 0) begin
        if (v.c > 0 && n == s + v.c) begin
          dout_done = 1'b1;
          abort     = v.ab;
        end
        if (n == s + v.c + 1) begin
          dout_done = 1'b0;
          abort     = 1'b0;
        end
        if (v.u > 0 && n == s + v.c + v.u) ethernet_read_done = 1'b1;
        if (n == s + v.c + v.u + 1) ethernet_read_done = 1'b0;
        if (v.chg && n == s + 1) begin
          sample_num     = 32'd200;
          sample_clk_cfg = ~v.sclk;
          sample_run     = 1'b0;
        end
        if (v.chg && n == s + 6) sample_run = 1'b1;
      end
    end
    if (!term) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_timeout actual=no_end required=end", tag);
    end
    g = sb.pop_front();
    chk({tag, "_end_step"}, 32'(n), 32'(g.end_step));
    chk({tag, "_start_step"}, 32'(s), 32'(g.start_step));
    chk({tag, "_err"}, 32'(err_code), 32'(g.err));
    chk({tag, "_cfg_num"}, cfg_sample_num, g.cfg_num);
    chk({tag, "_cfg_clk"}, 32'(cfg_sample_clk), 32'(g.cfg_clk));
    chk({tag, "_cfg_trig"}, 32'({cfg_triger_type, cfg_trig_chan}),
        32'({g.cfg_trig, g.cfg_chan}));
    chk({tag, "_run_count"}, 32'(run_count), 32'(g.rc));
    chk({tag, "_path"}, 32'(mp), 32'(g.path));
    chk({tag, "_led_err"}, 32'(led_err), 32'(!g.done));
    step();
    if (run_done) dc++;
    if (start_posedge) sc++;
    chk({tag, "_start_cnt"}, 32'(sc), (v.num != 0) ? 32'd1 : 32'd0);
    chk({tag, "_done_cnt"}, 32'(dc), 32'(g.done));
    chk({tag, "_final_st"}, 32'(state), g.done ? 32'd0 : 32'd6);
    chk({tag, "_busy"}, 32'({busy, led_busy}), 32'd0);
    sample_run         = 1'b0;
    ddr_init_done      = 1'b1;
    dout_done          = 1'b0;
    ethernet_read_done = 1'b0;
    abort              = 1'b0;
    repeat (4) step();
    m_rc = g.rc;
    m_st = g.done ? 0 : 6;
  endtask

  initial begin
    int k;
    vecs[0] = '{32'h3FDD, 4'h3, 2'd1, 3'd2, 0,   50, 20, 1'b0, 1'b0};
    vecs[1] = '{32'h40,   4'h5, 2'd2, 3'd7, 100, 10, 5,  1'b0, 1'b0};
    vecs[2] = '{32'h0,    4'h9, 2'd3, 3'd1, 0,   10, 5,  1'b0, 1'b0};
    vecs[3] = '{32'h10,   4'h1, 2'd0, 3'd4, 0,   5,  3,  1'b0, 1'b0};
    vecs[4] = '{32'h20,   4'h2, 2'd1, 3'd3, 0,   0,  5,  1'b0, 1'b0};
    vecs[5] = '{32'h30,   4'hA, 2'd2, 3'd5, 0,   8,  4,  1'b0, 1'b0};
    vecs[6] = '{32'h50,   4'hC, 2'd3, 3'd6, 0,   12, 5,  1'b1, 1'b0};
    vecs[7] = '{32'd100,  4'h7, 2'd1, 3'd0, 0,   30, 6,  1'b0, 1'b1};
    vecs[8] = '{32'h70,   4'hE, 2'd0, 3'd2, 0,   5,  0,  1'b0, 1'b0};

    rst_n              = 1'b0;
    sample_run         = 1'b0;
    abort              = 1'b0;
    sample_clk_cfg     = 4'hF;
    sample_num         = 32'hFFFF;
    triger_type        = 2'd3;
    trigger_channel    = 3'd7;
    ddr_init_done      = 1'b1;
    dout_done          = 1'b0;
    ethernet_read_done = 1'b0;
    repeat (3) step();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_outs", 32'({start_posedge, busy, run_done, led_busy, led_err}), 32'd0);
    chk("rst_cfg", cfg_sample_num, 32'd0);
    chk("rst_cfg_misc",
        32'({cfg_sample_clk, cfg_triger_type, cfg_trig_chan}), 32'd0);
    chk("rst_cnt_err", 32'({run_count, err_code}), 32'd0);
    rst_n = 1'b1;
    repeat (3) step();

    // abort in IDLE has no effect
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    chk("idle_abort_st", 32'(state), 32'd0);
    chk("idle_abort_err", 32'(err_code), 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], i);
      if (i == 6) begin
        // abort while in ERROR returns to IDLE and clears the cause
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("err_abort_st", 32'(state), 32'd0);
        chk("err_abort_err", 32'(err_code), 32'd0);
        chk("err_abort_led", 32'(led_err), 32'd0);
        m_st = 0;
        repeat (2) step();
      end
    end

    // asynchronous reset in the middle of a capture
    sample_num = 32'h99;
    sample_run = 1'b1;
    k = 0;
    while (state != 3'd3 && k < 20) begin
      step();
      k++;
    end
    chk("mid_reach_cap", 32'(state), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_outs", 32'({run_done, busy, start_posedge}), 32'd0);
    chk("mid_rst_cnt", 32'(run_count), 32'd0);
    chk("mid_rst_cfg", cfg_sample_num, 32'd0);
    sample_run = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (6) step();
    chk("post_rst_idle", 32'({state, run_done}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
